// File: rtl/graph_pkg.sv
// Shared definitions for the graph row reader: scan FSM states, default widths
// and the edge staging FIFO depth.
package graph_pkg;

    localparam int GRAPH_DATA_WIDTH = 16;
    localparam int GRAPH_NODE_WIDTH = 3;
    localparam int EDGE_FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/graph_row_reader_edge_fifo.sv
// Small synchronous FIFO staging kept edges; data visible the cycle after push.
// Push is refused when full unless a pop frees a slot in the same cycle.
module edge_fifo
    import graph_pkg::*;
#(
    parameter int WIDTH = GRAPH_NODE_WIDTH + GRAPH_DATA_WIDTH,
    parameter int DEPTH = EDGE_FIFO_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = store[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/graph_row_reader.sv
// Scans one adjacency-matrix row and streams its nonzero off-diagonal edges in column order.
// One column per cycle; reads are throttled so FIFO entries plus reads in flight never exceed two.
module graph_row_reader
    import graph_pkg::*;
#(
    parameter int DATA_WIDTH = GRAPH_DATA_WIDTH,
    parameter int NODE_WIDTH = GRAPH_NODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [NODE_WIDTH-1:0]   req_node,
    output logic [2*NODE_WIDTH-1:0] mem_addr,
    output logic                    mem_rd,
    input  logic [DATA_WIDTH-1:0]   mem_q,
    output logic                    edge_valid,
    input  logic                    edge_ready,
    output logic [NODE_WIDTH-1:0]   edge_node,
    output logic [DATA_WIDTH-1:0]   edge_weight,
    output logic                    row_done,
    output logic [NODE_WIDTH:0]     edge_count
);

    localparam int ADDR_WIDTH  = 2 * NODE_WIDTH;
    localparam int ENTRY_WIDTH = NODE_WIDTH + DATA_WIDTH;
    localparam int CNT_W       = count_width(EDGE_FIFO_DEPTH);
    localparam int OCC_W       = CNT_W + 1;
    localparam logic [NODE_WIDTH-1:0] LAST_COL = '1;

    scan_state_t            state;
    logic [NODE_WIDTH-1:0]  row;
    logic [NODE_WIDTH-1:0]  col;
    logic [NODE_WIDTH-1:0]  cap_col;
    logic                   inflight;
    logic [ADDR_WIDTH-1:0]  addr_q;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [ENTRY_WIDTH-1:0] fifo_head;
    logic [OCC_W-1:0]       occupancy;
    logic                   credit;
    logic                   issue;
    logic                   keep;

    assign fifo_pop   = !fifo_empty && edge_ready;
    assign edge_valid = !fifo_empty;
    assign {edge_node, edge_weight} = fifo_head;

    // Occupancy counts reads in flight as well as staged entries, so a full
    // FIFO and an outstanding read can never collide; a same-cycle pop frees one slot.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
    assign credit    = (occupancy < OCC_W'(EDGE_FIFO_DEPTH)) ||
                       ((occupancy == OCC_W'(EDGE_FIFO_DEPTH)) && fifo_pop);
    assign issue     = (state == ST_SCAN) && credit;

    assign mem_rd   = issue;
    assign mem_addr = issue ? {row, col} : addr_q;

    assign keep      = (mem_q != '0) && (cap_col != row);
    assign fifo_push = inflight && keep && (!fifo_full || fifo_pop);

    edge_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (EDGE_FIFO_DEPTH)
    ) u_edge_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({cap_col, mem_q}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            row        <= '0;
            col        <= '0;
            cap_col    <= '0;
            inflight   <= 1'b0;
            addr_q     <= '0;
            edge_count <= '0;
            req_ready  <= 1'b0;
            row_done   <= 1'b0;
        end else begin
            inflight <= issue;
            row_done <= 1'b0;
            if (issue) begin
                cap_col <= col;
                addr_q  <= {row, col};
            end
            if (fifo_pop) begin
                edge_count <= edge_count + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        row        <= req_node;
                        col        <= '0;
                        edge_count <= '0;
                        req_ready  <= 1'b0;
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // The last column ends the scan instead of wrapping back to zero.
                    if (issue) begin
                        if (col == LAST_COL) begin
                            state <= ST_DRAIN;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!inflight && fifo_empty) begin
                        row_done <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    req_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_graph_row_reader.sv
// Directed bench for graph_row_reader: table of row scans plus stall, reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_graph_row_reader;
    import graph_pkg::*;

    localparam int DW = 16;
    localparam int NW = 3;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [NW-1:0]   req_node;
    logic [2*NW-1:0] mem_addr;
    logic            mem_rd;
    logic [DW-1:0]   mem_q;
    logic            edge_valid;
    logic            edge_ready;
    logic [NW-1:0]   edge_node;
    logic [DW-1:0]   edge_weight;
    logic            row_done;
    logic [NW:0]     edge_count;

    graph_row_reader #(.DATA_WIDTH(DW), .NODE_WIDTH(NW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_node    (req_node),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_q       (mem_q),
        .edge_valid  (edge_valid),
        .edge_ready  (edge_ready),
        .edge_node   (edge_node),
        .edge_weight (edge_weight),
        .row_done    (row_done),
        .edge_count  (edge_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Graph memory model: read data appears one cycle after the issue cycle.
    logic [DW-1:0]   gmem [64];
    logic            rd_s;
    logic [2*NW-1:0] addr_s;
    initial begin
        rd_s   = 1'b0;
        addr_s = '0;
        forever begin
            @(negedge clk);
            rd_s   = mem_rd;
            addr_s = mem_addr;
        end
    end
    initial begin
        mem_q = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_s) mem_q = gmem[addr_s];
        end
    end

    // 0: always ready, 1: toggle every cycle, other: held low
    int ready_mode;
    initial begin
        edge_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       edge_ready = 1'b1;
                1:       edge_ready = ~edge_ready;
                default: edge_ready = 1'b0;
            endcase
        end
    end

    // Monitor: logs handshakes, row_done pulses and accepts; checks payload hold while stalled.
    int            cyc, ecnt, done_cnt, acc_cnt, rd_total, kept_issued, popped;
    logic [NW-1:0] ecol [256];
    logic [DW-1:0] ew   [256];
    int            acc_log  [64];
    int            done_log [64];
    logic [NW:0]   done_ecount;
    logic          stalled_prev;
    logic [NW-1:0] prev_node;
    logic [DW-1:0] prev_w;
    logic          occ_chk;
    int            occ_base;

    initial begin
        cyc = 0; ecnt = 0; done_cnt = 0; acc_cnt = 0;
        rd_total = 0; kept_issued = 0; popped = 0;
        done_ecount = '0; stalled_prev = 1'b0; prev_node = '0; prev_w = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (stalled_prev && !reset) begin
                check("hold_valid", 32'(edge_valid), 1);
                check("hold_node", 32'(edge_node), 32'(prev_node));
                check("hold_weight", 32'(edge_weight), 32'(prev_w));
            end
            stalled_prev = edge_valid && !edge_ready;
            prev_node    = edge_node;
            prev_w       = edge_weight;
            if (edge_valid && edge_ready) begin
                ecol[ecnt[7:0]] = edge_node;
                ew[ecnt[7:0]]   = edge_weight;
                ecnt++;
                popped++;
            end
            if (mem_rd) begin
                rd_total++;
                if (gmem[mem_addr] != '0 && mem_addr[5:3] != mem_addr[2:0]) kept_issued++;
            end
            if (occ_chk) check("occupancy_le2", 32'((kept_issued - popped - occ_base) <= 2), 1);
            if (row_done) begin
                done_log[done_cnt[5:0]] = cyc;
                done_cnt++;
                done_ecount = edge_count;
            end
            if (req_valid && req_ready) begin
                acc_log[acc_cnt[5:0]] = cyc;
                acc_cnt++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [2:0]        node;
        logic [1:0]        mode;
        logic [3:0]        exp_cnt;
        logic [7:0]        exp_lat;   // accept-to-row_done cycles, 0 = not checked
        logic [7:0][2:0]   cols;
        logic [7:0][15:0]  ws;
    } vec_t;

    vec_t vt [5];

    task automatic send_req(input logic [NW-1:0] n);
        int t;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!req_ready && t < 100);
        check("req_ready_wait", 32'(req_ready), 1);
        req_node  = n;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int db);
        int t;
        t = 0;
        while (done_cnt == db && t < 400) begin
            @(posedge clk);
            t++;
        end
        check("row_done_seen", 32'(done_cnt > db), 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int eb, db, ab;
        eb = ecnt; db = done_cnt; ab = acc_cnt;
        ready_mode = int'(v.mode);
        send_req(v.node);
        wait_done(db);
        repeat (3) @(posedge clk);
        check({tag, "_edges"}, ecnt - eb, 32'(v.exp_cnt));
        for (int i = 0; i < 8; i++) begin
            if (i < int'(v.exp_cnt) && i < ecnt - eb) begin
                check({tag, "_col"}, 32'(ecol[8'(eb + i)]), 32'(v.cols[i]));
                check({tag, "_weight"}, 32'(ew[8'(eb + i)]), 32'(v.ws[i]));
            end
        end
        check({tag, "_done_pulses"}, done_cnt - db, 1);
        check({tag, "_count_at_done"}, 32'(done_ecount), 32'(v.exp_cnt));
        check({tag, "_count_held"}, 32'(edge_count), 32'(v.exp_cnt));
        if (v.exp_lat != 0)
            check({tag, "_latency"}, done_log[db[5:0]] - acc_log[ab[5:0]], 32'(v.exp_lat));
    endtask

    initial begin
        int eb, db, ab, rb, t;
        vec_t v;
        checks = 0; failures = 0;
        reset = 1'b1; req_valid = 1'b0; req_node = '0;
        ready_mode = 0; occ_chk = 1'b0; occ_base = 0;

        for (int i = 0; i < 64; i++) gmem[i] = '0;
        gmem[{3'd2, 3'd1}] = 16'd5;
        gmem[{3'd2, 3'd4}] = 16'd7;
        gmem[{3'd2, 3'd7}] = 16'd3;
        gmem[{3'd3, 3'd3}] = 16'd9;
        for (int i = 0; i < 8; i++) gmem[{3'd0, 3'(i)}] = 16'd1;
        gmem[{3'd5, 3'd0}] = 16'h0002;
        gmem[{3'd5, 3'd2}] = 16'h0011;
        gmem[{3'd5, 3'd5}] = 16'h0066;
        gmem[{3'd5, 3'd7}] = 16'h00A0;
        for (int i = 0; i < 8; i++) gmem[{3'd7, 3'(i)}] = 16'(16'h0100 + i);

        for (int k = 0; k < 5; k++) vt[k] = '0;
        vt[0].node = 3'd2; vt[0].mode = 2'd0; vt[0].exp_cnt = 4'd3; vt[0].exp_lat = 8'd12;
        vt[0].cols[0] = 3'd1; vt[0].ws[0] = 16'd5;
        vt[0].cols[1] = 3'd4; vt[0].ws[1] = 16'd7;
        vt[0].cols[2] = 3'd7; vt[0].ws[2] = 16'd3;
        vt[1].node = 3'd3; vt[1].mode = 2'd0; vt[1].exp_cnt = 4'd0; vt[1].exp_lat = 8'd11;
        vt[2].node = 3'd0; vt[2].mode = 2'd1; vt[2].exp_cnt = 4'd7; vt[2].exp_lat = 8'd0;
        for (int i = 0; i < 7; i++) begin
            vt[2].cols[i] = 3'(i + 1);
            vt[2].ws[i]   = 16'd1;
        end
        vt[3].node = 3'd5; vt[3].mode = 2'd0; vt[3].exp_cnt = 4'd3; vt[3].exp_lat = 8'd12;
        vt[3].cols[0] = 3'd0; vt[3].ws[0] = 16'h0002;
        vt[3].cols[1] = 3'd2; vt[3].ws[1] = 16'h0011;
        vt[3].cols[2] = 3'd7; vt[3].ws[2] = 16'h00A0;
        vt[4].node = 3'd7; vt[4].mode = 2'd0; vt[4].exp_cnt = 4'd7; vt[4].exp_lat = 8'd11;
        for (int i = 0; i < 7; i++) begin
            vt[4].cols[i] = 3'(i);
            vt[4].ws[i]   = 16'(16'h0100 + i);
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_edge_valid", 32'(edge_valid), 0);
        check("rst_row_done", 32'(row_done), 0);
        check("rst_edge_node", 32'(edge_node), 0);
        check("rst_edge_weight", 32'(edge_weight), 0);
        check("rst_edge_count", 32'(edge_count), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(req_ready), 1);

        for (int k = 0; k < 5; k++) begin
            v = vt[k];
            run_vec(v, $sformatf("vec%0d", k));
        end

        // Long stall after the first edge of row 0
        ready_mode = 0;
        eb = ecnt; db = done_cnt;
        occ_base = kept_issued - popped;
        occ_chk = 1'b1;
        send_req(3'd0);
        t = 0;
        while (ecnt == eb && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("stall_first_edge", 32'(ecnt > eb), 1);
        ready_mode = 2;
        repeat (3) @(posedge clk);
        rb = rd_total;
        repeat (17) @(posedge clk);
        #1;
        check("stall_no_reads", rd_total - rb, 0);
        check("stall_accepted", ecnt - eb, 1);
        check("stall_valid_held", 32'(edge_valid), 1);
        ready_mode = 0;
        wait_done(db);
        occ_chk = 1'b0;
        check("stall_total_edges", ecnt - eb, 7);
        for (int i = 0; i < 7; i++) begin
            check("stall_col", 32'(ecol[8'(eb + i)]), 32'(i + 1));
        end

        // Reset three cycles into a scan of row 2
        repeat (2) @(posedge clk);
        ready_mode = 0;
        eb = ecnt; db = done_cnt;
        send_req(3'd2);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 0);
        check("mid_rst_mem_rd", 32'(mem_rd), 0);
        check("mid_rst_mem_addr", 32'(mem_addr), 0);
        check("mid_rst_edge_valid", 32'(edge_valid), 0);
        check("mid_rst_row_done", 32'(row_done), 0);
        check("mid_rst_edge_node", 32'(edge_node), 0);
        check("mid_rst_edge_weight", 32'(edge_weight), 0);
        check("mid_rst_edge_count", 32'(edge_count), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        check("abort_edges", ecnt - eb, 0);
        check("abort_done", done_cnt - db, 0);
        v = vt[3];
        run_vec(v, "after_rst");

        // Back-to-back requests with req_valid held high
        ready_mode = 0;
        eb = ecnt; db = done_cnt; ab = acc_cnt;
        @(posedge clk);
        #1;
        req_node  = 3'd2;
        req_valid = 1'b1;
        t = 0;
        while (acc_cnt == ab && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        req_node = 3'd3;
        t = 0;
        while (acc_cnt < ab + 2 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc_cnt - ab, 2);
        check("b2b_done_between", done_cnt - db, 1);
        check("b2b_gap", acc_log[6'(ab + 1)] - done_log[db[5:0]], 1);
        wait_done(db + 1);
        repeat (3) @(posedge clk);
        check("b2b_edges", ecnt - eb, 3);
        check("b2b_second_count", 32'(done_ecount), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/graph_row_reader.md
GRAPH_ROW_READER -- requirements
Module: graph_row_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning edge-weight width; must equal the graph memory word width.
REQ-002 SHALL have parameter NODE_WIDTH, default 3, meaning node index width; N = 2**NODE_WIDTH nodes; local ADDR_WIDTH = 2*NODE_WIDTH.
REQ-003 SHALL have clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have req_valid  input  1  row-scan request.
REQ-006 SHALL have req_ready  output  1  request accepted when req_valid & req_ready.
REQ-007 SHALL have req_node  input  NODE_WIDTH  source node (row) to scan.
REQ-008 SHALL have mem_addr  output  ADDR_WIDTH  graph memory read address, {row, col}.
REQ-009 SHALL have mem_rd  output  1  high in cycles where mem_addr is a new read issue.
REQ-010 SHALL have mem_q  input  DATA_WIDTH  memory read data, valid exactly one cycle after issue.
REQ-011 SHALL have edge_valid / edge_ready  output / input  1 each  edge stream handshake.
REQ-012 SHALL have edge_node  output  NODE_WIDTH  destination node (column) of the edge.
REQ-013 SHALL have edge_weight  output  DATA_WIDTH  nonzero edge weight.
REQ-014 SHALL have row_done  output  1  one-cycle pulse when the row is fully scanned and drained.
REQ-015 SHALL have edge_count  output  NODE_WIDTH+1  edges emitted for the current row.

Function
REQ-016 SHALL implement FSM IDLE, SCAN, DRAIN, DONE; req_ready = 1 only in IDLE.
REQ-017 IDLE: on req_valid, SHALL latch req_node as row, set col = 0, clear edge_count, go to SCAN.
REQ-018 SCAN: SHALL issue read {row, col} with mem_rd = 1 when credit exists; then col increments; after issuing col = N-1, go to DRAIN.
REQ-019 Credit SHALL exist when fifo_count + inflight < 2, or when it equals 2 and an edge pop occurs the same cycle.
REQ-020 The cycle after an issue, SHALL capture mem_q with the issued col; entries with weight 0 or col == row SHALL be dropped, all others written to a 2-entry FIFO.
REQ-021 edge_valid SHALL equal FIFO non-empty; edge_node and edge_weight SHALL come from the FIFO head and stay stable while edge_valid & !edge_ready.
REQ-022 edge_count SHALL increment on each edge_valid & edge_ready handshake.
REQ-023 Edges SHALL be emitted in ascending column order.
REQ-024 Throughput SHALL be one column per cycle while edge_ready = 1.
REQ-025 DRAIN: SHALL go to DONE when inflight = 0 and FIFO is empty.
REQ-026 DONE: row_done SHALL be 1 for exactly one cycle, then return to IDLE.
REQ-027 If a row has no edges, SHALL still pulse row_done, with edge_count = 0.
REQ-028 mem_addr SHALL hold its last value when mem_rd = 0.
REQ-029 A FIFO push and pop in the same cycle SHALL both take effect, with count unchanged.
REQ-030 col SHALL not wrap within a scan; the request is complete after col N-1.

Reset
REQ-031 Reset SHALL asynchronously force IDLE, col = 0, row = 0, FIFO empty, inflight = 0, and edge_count = 0.
REQ-032 During reset, outputs SHALL be: req_ready = 0, mem_rd = 0, mem_addr = 0, edge_valid = 0, row_done = 0, edge_node = 0, edge_weight = 0.
REQ-033 After reset deasserts, req_ready SHALL be 1 from the first clock in IDLE.
REQ-034 Reset mid-scan SHALL discard in-flight read data; no edge and no row_done from the aborted row SHALL appear.

Structure
REQ-035 State enum and the default widths SHALL live in a shared graph_pkg.
REQ-036 The 2-entry FIFO SHALL be a sub-module edge_fifo (push/pop/full/empty/count).

Verification
REQ-037 N=8, row 2 = {0,5,0,0,7,0,0,3}, edge_ready = 1: req_node = 2 -> edges (1,5), (4,7), (7,3) on consecutive-capable cycles; row_done once; edge_count = 3.
REQ-038 Row 3 all zero except diagonal [3] = 9: -> no edge_valid; row_done pulse; edge_count = 0.
REQ-039 Row 0 all weights 1, edge_ready toggling 1/0 each cycle: -> 7 edges, cols 1..7 in order, payload stable while stalled, no loss or duplication.
REQ-040 edge_ready held 0 for 20 cycles mid-row: -> at most 2 reads outstanding beyond accepted edges (FIFO + inflight ≤ 2), mem_rd stalls; all edges delivered after release.
REQ-041 Reset asserted 3 cycles into a scan of row 2: -> outputs reach reset values immediately; the next request for row 5 yields only row-5 edges.
REQ-042 req_valid held high across back-to-back requests: -> second request accepted only in the IDLE cycle after row_done; no overlap.
